// File: rtl/system_leds_pio_if.sv
// Avalon-MM slave bus of the LED output PIO: word-addressed writes and
// registered reads between the interconnect (master) and the PIO (slave).
interface system_leds_pio_if;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output chipselect, address, write_n, writedata, input readdata);
  modport slave  (input chipselect, address, write_n, writedata, output readdata);
endinterface

// File: rtl/system_leds_pio.sv
// LED output PIO with DATA, atomic OUTSET/OUTCLEAR and a registered read port.
// Define LEDPIO_BLINK_EN to add the blink engine (BLINK_MASK, BLINK_PERIOD, STATUS).
module system_leds_pio #(
  parameter int              WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int              CNT_W       = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  system_leds_pio_if.slave  bus,
  output logic [WIDTH-1:0]  out_port
);
  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [31:0]      w_rdata;
  logic             w_unused;
  logic [WIDTH-1:0] r_data;
  logic [31:0]      r_readdata;

  assign w_wr     = bus.chipselect & ~bus.write_n;
  assign w_wd     = bus.writedata[WIDTH-1:0];
  assign w_unused = &{1'b0, bus.writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= RESET_VALUE;
    end else if (w_wr) begin
      case (bus.address)
        A_DATA:  r_data <= w_wd;
        A_SET:   r_data <= r_data | w_wd;
        A_CLR:   r_data <= r_data & ~w_wd;
        default: ;
      endcase
    end
  end

`ifdef LEDPIO_BLINK_EN
  localparam logic [2:0] A_MASK   = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;

  logic [WIDTH-1:0] r_mask;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic             w_active;
  logic             w_wrap;

  assign w_active = (r_period != '0);
  assign w_wrap   = (r_cnt == r_period - CNT_W'(1));

  // A period write restarts the blink from phase 0; a mask write leaves it running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask   <= '0;
      r_period <= '0;
      r_cnt    <= '0;
      r_phase  <= 1'b0;
    end else begin
      if (w_wr && bus.address == A_MASK) r_mask <= w_wd;
      if (w_wr && bus.address == A_PERIOD) begin
        r_period <= bus.writedata[CNT_W-1:0];
        r_cnt    <= '0;
        r_phase  <= 1'b0;
      end else if (!w_active) begin
        r_cnt    <= '0;
        r_phase  <= 1'b0;
      end else if (w_wrap) begin
        r_cnt    <= '0;
        r_phase  <= ~r_phase;
      end else begin
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out_port = r_data ^ (r_mask & {WIDTH{r_phase}});
`else
  assign out_port = r_data;
`endif

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      A_DATA:   w_rdata[WIDTH-1:0] = r_data;
`ifdef LEDPIO_BLINK_EN
      A_MASK:   w_rdata[WIDTH-1:0] = r_mask;
      A_PERIOD: w_rdata[CNT_W-1:0] = r_period;
      A_STATUS: w_rdata[1:0]       = {w_active, r_phase};
`endif
      default:  ;
    endcase
  end

  // Reads have no strobe: the addressed register is captured every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rdata;
  end

  assign bus.readdata = r_readdata;
endmodule

// File: tb/tb_system_leds_pio.sv
// Self-checking bench for system_leds_pio: directed scenarios plus random traffic
// against a cycle-count based model; compile with LEDPIO_BLINK_EN to cover blinking.
module tb_system_leds_pio;
  localparam int W  = 10;
  localparam int CW = 24;
  localparam logic [W-1:0] RV = 10'h155;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] out_port;
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;

  system_leds_pio_if bus ();

  system_leds_pio #(.WIDTH(W), .RESET_VALUE(RV), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: register contents plus the edge count at which the period was last written.
  logic [W-1:0] m_data, m_mask;
  int           m_period, m_e;

  function automatic void m_reset();
    m_data = RV; m_mask = '0; m_period = 0; m_e = 0;
  endfunction

  // Phase after edge n: number of whole periods elapsed since the period write, mod 2.
  function automatic logic m_phase(input int n);
    if (m_period == 0) return 1'b0;
    return (((n - m_e) / m_period) % 2) == 1;
  endfunction

  function automatic logic [W-1:0] exp_out(input int n);
    return m_data ^ (m_mask & {W{m_phase(n)}});
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] a, input int n);
    case (a)
      3'd0: return 32'(m_data);
`ifdef LEDPIO_BLINK_EN
      3'd1: return 32'(m_mask);
      3'd2: return 32'(m_period);
      3'd3: return {30'b0, m_period != 0, m_phase(n)};
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_apply(input logic [2:0] a, input logic [31:0] d);
    case (a)
      3'd0: m_data = d[W-1:0];
      3'd4: m_data = m_data | d[W-1:0];
      3'd5: m_data = m_data & ~d[W-1:0];
`ifdef LEDPIO_BLINK_EN
      3'd1: m_mask = d[W-1:0];
      3'd2: begin m_period = int'(d[CW-1:0]); m_e = cyc; end
`endif
      default: ;
    endcase
  endfunction

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    m_apply(a, d);
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] rd, output logic [31:0] ex);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
    @(posedge clk); #1;
    ex = exp_read(a, cyc - 1);
    bus.chipselect = 1'b0;
    @(negedge clk);
    rd = bus.readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd, ex;
    #2;
    n_chk++; if (out_port !== RV) begin n_fail++; $display("FAIL reset_out: got %h expected %h", out_port, RV); end
    n_chk++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h expected 0", bus.readdata); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    do_write(3'd0, 32'h3C3);
    do_read(3'd0, rd, ex);
    n_chk++; if (rd !== ex) begin n_fail++; $display("FAIL pre_reset_rd: got %h expected %h", rd, ex); end
    do_write(3'd0, 32'h2AA);
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (out_port !== RV) begin n_fail++; $display("FAIL async_reset_out: got %h expected %h", out_port, RV); end
    n_chk++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL async_reset_rd: got %h expected 0", bus.readdata); end
    m_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_chk++; if (out_port !== RV) begin n_fail++; $display("FAIL post_reset_out: got %h expected %h", out_port, RV); end
  endtask

  task automatic test_data();
    logic [31:0] rd, ex;
    do_write(3'd0, 32'h2A5);
    @(negedge clk);
    n_chk++; if (out_port !== 10'h2A5) begin n_fail++; $display("FAIL data_out: got %h expected 2a5", out_port); end
    do_read(3'd0, rd, ex);
    n_chk++; if (rd !== 32'h2A5) begin n_fail++; $display("FAIL data_rd: got %h expected 2a5", rd); end
    do_write(3'd0, 32'hFFFF_FD5A);
    @(negedge clk);
    n_chk++; if (out_port !== 10'h15A) begin n_fail++; $display("FAIL data_trunc: got %h expected 15a", out_port); end
  endtask

  task automatic test_setclr();
    logic [31:0] rd, ex;
    do_write(3'd0, 32'h0);
    do_write(3'd4, 32'h3);
    @(negedge clk);
    n_chk++; if (out_port !== 10'h003) begin n_fail++; $display("FAIL outset: got %h expected 003", out_port); end
    do_write(3'd5, 32'h1);
    @(negedge clk);
    n_chk++; if (out_port !== 10'h002) begin n_fail++; $display("FAIL outclear: got %h expected 002", out_port); end
    do_read(3'd4, rd, ex);
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL outset_rd: got %h expected 0", rd); end
    do_read(3'd5, rd, ex);
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL outclear_rd: got %h expected 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 24; i++) begin
      a = (i % 3 == 0) ? 3'd0 : ((i % 3 == 1) ? 3'd4 : 3'd5);
      d = $urandom;
      @(negedge clk);
      if (i > 0) begin
        n_chk++; if (out_port !== exp_out(cyc)) begin n_fail++; $display("FAIL b2b_out[%0d]: got %h expected %h", i, out_port, exp_out(cyc)); end
      end
      bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
      @(posedge clk); #1;
      m_apply(a, d);
    end
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    @(negedge clk);
    n_chk++; if (out_port !== exp_out(cyc)) begin n_fail++; $display("FAIL b2b_last: got %h expected %h", out_port, exp_out(cyc)); end
  endtask

`ifdef LEDPIO_BLINK_EN
  task automatic test_blink();
    logic [31:0] rd, ex;
    logic [W-1:0] want;
    do_write(3'd0, 32'h0F0);
    do_write(3'd1, 32'h00F);
    do_write(3'd2, 32'd4);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      want = (((i / 4) % 2) == 1) ? 10'h0FF : 10'h0F0;
      n_chk++; if (out_port !== want) begin n_fail++; $display("FAIL blink_out[%0d]: got %h expected %h", i, out_port, want); end
    end
    for (int i = 0; i < 6; i++) begin
      do_read(3'd3, rd, ex);
      n_chk++; if (rd !== ex) begin n_fail++; $display("FAIL blink_status[%0d]: got %h expected %h", i, rd, ex); end
    end
    do_write(3'd1, 32'h00C);
    repeat (5) begin
      @(negedge clk);
      n_chk++; if (out_port !== exp_out(cyc)) begin n_fail++; $display("FAIL mask_rewrite: got %h expected %h", out_port, exp_out(cyc)); end
    end
  endtask

  task automatic test_blink_stop();
    logic [31:0] rd, ex;
    do_write(3'd1, 32'h00F);
    do_write(3'd2, 32'd0);
    @(negedge clk);
    n_chk++; if (out_port !== 10'h0F0) begin n_fail++; $display("FAIL stop_out: got %h expected 0f0", out_port); end
    do_read(3'd3, rd, ex);
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL stop_status: got %h expected 0", rd); end
    do_write(3'd2, 32'd3);
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_chk++; if (out_port !== RV) begin n_fail++; $display("FAIL blink_reset_out: got %h expected %h", out_port, RV); end
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    do_read(3'd1, rd, ex);
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL blink_reset_mask: got %h expected 0", rd); end
    do_read(3'd3, rd, ex);
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL blink_reset_status: got %h expected 0", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, ex;
    do_write(3'd1, 32'h3FF);
    do_write(3'd2, 32'hFFFF_FFFF);
    do_read(3'd2, rd, ex);
    n_chk++; if (rd !== 32'h00FF_FFFF) begin n_fail++; $display("FAIL wrap_period: got %h expected 00ffffff", rd); end
    repeat (10) @(posedge clk);
    do_read(3'd3, rd, ex);
    n_chk++; if (rd !== 32'h2) begin n_fail++; $display("FAIL wrap_status: got %h expected 2", rd); end
    n_chk++; if (out_port !== m_data) begin n_fail++; $display("FAIL wrap_out: got %h expected %h", out_port, m_data); end
  endtask
`else
  task automatic test_noblink();
    logic [31:0] rd, ex;
    do_write(3'd0, 32'h1A6);
    do_write(3'd1, 32'h3FF);
    do_write(3'd2, 32'd2);
    repeat (6) begin
      @(negedge clk);
      n_chk++; if (out_port !== 10'h1A6) begin n_fail++; $display("FAIL noblink_out: got %h expected 1a6", out_port); end
    end
    for (int a = 1; a <= 3; a++) begin
      do_read(3'(a), rd, ex);
      n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL noblink_rd@%0d: got %h expected 0", a, rd); end
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] rd, ex, d;
    logic [2:0]  a;
    for (int i = 0; i < 200; i++) begin
      a = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: begin
          d = (a == 3'd2) ? (32'($urandom_range(0, 6)) | ($urandom << CW)) : $urandom;
          do_write(a, d);
          @(negedge clk);
          n_chk++; if (out_port !== exp_out(cyc)) begin n_fail++; $display("FAIL rnd_wr_out[%0d]: got %h expected %h", i, out_port, exp_out(cyc)); end
        end
        1: begin
          do_read(a, rd, ex);
          n_chk++; if (rd !== ex) begin n_fail++; $display("FAIL rnd_rd@%0d[%0d]: got %h expected %h", a, i, rd, ex); end
        end
        default: begin
          repeat ($urandom_range(1, 5)) @(posedge clk);
          @(negedge clk);
          n_chk++; if (out_port !== exp_out(cyc)) begin n_fail++; $display("FAIL rnd_idle_out[%0d]: got %h expected %h", i, out_port, exp_out(cyc)); end
        end
      endcase
    end
  endtask

  initial begin
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 3'd0; bus.writedata = 32'h0;
    m_reset();
    #1 reset_n = 1'b0;
    test_reset();
    test_data();
    test_setclr();
    test_back_to_back();
`ifdef LEDPIO_BLINK_EN
    test_blink();
    test_blink_stop();
    test_wrap();
`else
    test_noblink();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
